// File: rtl/vending_pkg.sv
// vending_pkg: shared states, coin encodings and amount width
// for the vending-machine change dispenser.
package vending_pkg;

    localparam int AMT_W = 3;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        EJECT,
        FINISH,
        FAULT
    } state_t;

    localparam logic COIN1 = 1'b0;
    localparam logic COIN2 = 1'b1;

    localparam logic [AMT_W-1:0] COIN1_VAL = AMT_W'(1);
    localparam logic [AMT_W-1:0] COIN2_VAL = AMT_W'(2);

    function automatic logic [AMT_W-1:0] coin_value(input logic sel);
        return (sel == COIN2) ? COIN2_VAL : COIN1_VAL;
    endfunction

endpackage

// File: rtl/coin_tube.sv
// coin_tube: one coin tube inventory, saturating at TUBE_DEPTH,
// reloaded to INIT_CNT on reset.
module coin_tube #(
    parameter int TUBE_W     = 4,
    parameter int TUBE_DEPTH = 15,
    parameter int INIT_CNT   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              dec,
    output logic [TUBE_W-1:0] count,
    output logic              empty
);

    localparam logic [TUBE_W-1:0] FULL = TUBE_W'(TUBE_DEPTH);
    localparam logic [TUBE_W-1:0] LOAD = TUBE_W'(INIT_CNT);
    localparam logic [TUBE_W-1:0] ONE  = TUBE_W'(1);

    logic [TUBE_W-1:0] count_q;
    logic [TUBE_W-1:0] count_d;

    // Refill saturates, eject never underflows, both at once cancel.
    always_comb begin
        count_d = count_q;
        if (inc && !dec) begin
            if (count_q < FULL) count_d = count_q + ONE;
        end else if (dec && !inc) begin
            if (count_q != '0) count_d = count_q - ONE;
        end
    end

    // Inventory register, reloaded on reset.
    always_ff @(posedge clk) begin
        if (rst) count_q <= LOAD;
        else     count_q <= count_d;
    end

    assign count = count_q;
    assign empty = (count_q == '0);

endmodule

// File: rtl/vending_change_dispenser.sv
// vending_change_dispenser: pays owed change greedily from a 2-unit
// and a 1-unit tube, one coin per ejector handshake.
module vending_change_dispenser
    import vending_pkg::*;
#(
    parameter int TUBE_W     = 4,
    parameter int TUBE_DEPTH = 15,
    parameter int INIT_CNT   = 8,
    parameter int TIMEOUT    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              chg_valid,
    input  logic [AMT_W-1:0]  chg_amt,
    output logic              chg_ready,
    output logic              eject,
    output logic              eject_sel,
    input  logic              eject_done,
    input  logic              refill,
    input  logic              refill_sel,
    output logic [TUBE_W-1:0] cnt1,
    output logic [TUBE_W-1:0] cnt2,
    output logic [AMT_W-1:0]  owed,
    output logic              done,
    output logic              short,
    output logic              fault
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TLAST = TMR_W'(TIMEOUT - 1);
    localparam logic [TMR_W-1:0] TONE  = TMR_W'(1);

    state_t             state_q;
    logic               ready_q;
    logic               eject_q;
    logic               sel_q;
    logic               done_q;
    logic               short_q;
    logic               fault_q;
    logic [AMT_W-1:0]   owed_q;
    logic [TMR_W-1:0]   timer_q;

    logic inc1, inc2, dec1, dec2;
    logic empty1, empty2;
    logic ack;

    assign ack  = (state_q == EJECT) && eject_done;
    assign dec1 = ack && (sel_q == COIN1);
    assign dec2 = ack && (sel_q == COIN2);
    assign inc1 = refill && (refill_sel == COIN1);
    assign inc2 = refill && (refill_sel == COIN2);

    coin_tube #(
        .TUBE_W     (TUBE_W),
        .TUBE_DEPTH (TUBE_DEPTH),
        .INIT_CNT   (INIT_CNT)
    ) u_tube1 (
        .clk   (clk),
        .rst   (rst),
        .inc   (inc1),
        .dec   (dec1),
        .count (cnt1),
        .empty (empty1)
    );

    coin_tube #(
        .TUBE_W     (TUBE_W),
        .TUBE_DEPTH (TUBE_DEPTH),
        .INIT_CNT   (INIT_CNT)
    ) u_tube2 (
        .clk   (clk),
        .rst   (rst),
        .inc   (inc2),
        .dec   (dec2),
        .count (cnt2),
        .empty (empty2)
    );

    // Payout sequencer with registered handshake and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            eject_q <= 1'b0;
            sel_q   <= COIN1;
            done_q  <= 1'b0;
            short_q <= 1'b0;
            fault_q <= 1'b0;
            owed_q  <= '0;
            timer_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (chg_valid) begin
                        ready_q <= 1'b0;
                        owed_q  <= chg_amt;
                        if (chg_amt == '0) begin
                            state_q <= FINISH;
                            done_q  <= 1'b1;
                            short_q <= 1'b0;
                        end else begin
                            state_q <= SELECT;
                        end
                    end
                end
                SELECT: begin
                    timer_q <= '0;
                    if (owed_q == '0) begin
                        state_q <= FINISH;
                        done_q  <= 1'b1;
                        short_q <= 1'b0;
                    end else if (owed_q >= COIN2_VAL && !empty2) begin
                        state_q <= EJECT;
                        eject_q <= 1'b1;
                        sel_q   <= COIN2;
                    end else if (!empty1) begin
                        state_q <= EJECT;
                        eject_q <= 1'b1;
                        sel_q   <= COIN1;
                    end else begin
                        // Only 2-unit coins left for a 1-unit debt: stop short.
                        state_q <= FINISH;
                        done_q  <= 1'b1;
                        short_q <= 1'b1;
                    end
                end
                EJECT: begin
                    if (eject_done) begin
                        owed_q  <= owed_q - coin_value(sel_q);
                        timer_q <= '0;
                        eject_q <= 1'b0;
                        state_q <= SELECT;
                    end else if (timer_q == TLAST) begin
                        eject_q <= 1'b0;
                        fault_q <= 1'b1;
                        state_q <= FAULT;
                    end else begin
                        timer_q <= timer_q + TONE;
                    end
                end
                FINISH: begin
                    short_q <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                FAULT: begin
                    state_q <= FAULT;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign chg_ready = ready_q;
    assign eject     = eject_q;
    assign eject_sel = sel_q;
    assign done      = done_q;
    assign short     = short_q;
    assign fault     = fault_q;
    assign owed      = owed_q;

endmodule

// File: tb/tb_vending_change_dispenser.sv
// tb_vending_change_dispenser: table-driven requests plus directed
// sequences for refill collisions, ejector timeout and mid-request reset.
module tb_vending_change_dispenser;

    logic       clk;
    logic       rst;
    logic       chg_valid;
    logic [2:0] chg_amt;
    logic       chg_ready;
    logic       eject;
    logic       eject_sel;
    logic       eject_done;
    logic       refill;
    logic       refill_sel;
    logic [3:0] cnt1;
    logic [3:0] cnt2;
    logic [2:0] owed;
    logic       done;
    logic       short;
    logic       fault;

    int checks;
    int failures;

    vending_change_dispenser #(
        .TUBE_W     (4),
        .TUBE_DEPTH (15),
        .INIT_CNT   (8),
        .TIMEOUT    (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .chg_valid  (chg_valid),
        .chg_amt    (chg_amt),
        .chg_ready  (chg_ready),
        .eject      (eject),
        .eject_sel  (eject_sel),
        .eject_done (eject_done),
        .refill     (refill),
        .refill_sel (refill_sel),
        .cnt1       (cnt1),
        .cnt2       (cnt2),
        .owed       (owed),
        .done       (done),
        .short      (short),
        .fault      (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         ref1;
        int         ref2;
        logic [2:0] amt;
        int         wt;
        int         n;
        logic [7:0] sels;
        logic       sh;
        logic [2:0] ow;
        int         lat;
        int         c1;
        int         c2;
    } vec_t;

    localparam int NV = 16;
    vec_t tbl [NV];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        chg_valid  = 1'b0;
        chg_amt    = '0;
        eject_done = 1'b0;
        refill     = 1'b0;
        refill_sel = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic refill_pulse(input logic s);
        @(negedge clk);
        refill     = 1'b1;
        refill_sel = s;
        @(negedge clk);
        refill     = 1'b0;
    endtask

    task automatic run_req(
        input  logic [2:0] amt,
        input  int         wt,
        output int         n,
        output logic [7:0] sels,
        output logic       sh,
        output logic [2:0] ow,
        output int         lat,
        output int         fe
    );
        int cyc;
        int wcnt;
        bit got;
        n    = 0;
        sels = '0;
        sh   = 1'b0;
        ow   = '0;
        lat  = -1;
        fe   = -1;
        wcnt = 0;
        got  = 1'b0;
        @(negedge clk);
        chg_valid = 1'b1;
        chg_amt   = amt;
        @(negedge clk);
        chg_valid = 1'b0;
        chg_amt   = '0;
        cyc = 1;
        while (!got && cyc < 200) begin
            eject_done = 1'b0;
            if (done) begin
                got = 1'b1;
                lat = cyc;
                sh  = short;
                ow  = owed;
            end else begin
                if (eject) begin
                    if (fe < 0) fe = cyc;
                    if (wcnt == wt) begin
                        sels[n]    = eject_sel;
                        n++;
                        eject_done = 1'b1;
                        wcnt       = 0;
                    end else begin
                        wcnt++;
                    end
                end
                @(negedge clk);
                cyc++;
            end
        end
        eject_done = 1'b0;
        if (!got) $display("FAIL req_timeout actual=no_done required=done");
    endtask

    int         n;
    logic [7:0] sels;
    logic       sh;
    logic [2:0] ow;
    int         lat;
    int         fe;
    int         k;
    int         ehigh;

    initial begin
        checks   = 0;
        failures = 0;

        // Expected results, hand-derived from 8/8 tubes at reset.
        tbl[0] = '{0, 0, 3'd3, 0, 2, 8'b01, 1'b0, 3'd0, 6, 7, 7};
        for (int i = 1; i <= 7; i++)
            tbl[i] = '{0, 0, 3'd2, 0, 1, 8'b1, 1'b0, 3'd0, 4, 7, 7 - i};
        tbl[8]  = '{0, 0, 3'd2, 0, 2, 8'b00, 1'b0, 3'd0, 6, 5, 0};
        tbl[9]  = '{0, 0, 3'd1, 0, 1, 8'b0, 1'b0, 3'd0, 4, 4, 0};
        tbl[10] = '{0, 0, 3'd7, 0, 4, 8'b0000, 1'b1, 3'd3, 10, 0, 0};
        tbl[11] = '{0, 3, 3'd5, 0, 2, 8'b11, 1'b1, 3'd1, 6, 0, 1};
        tbl[12] = '{0, 0, 3'd1, 0, 0, 8'b0, 1'b1, 3'd1, 2, 0, 1};
        tbl[13] = '{2, 0, 3'd2, 3, 1, 8'b1, 1'b0, 3'd0, 7, 2, 0};
        tbl[14] = '{0, 0, 3'd0, 0, 0, 8'b0, 1'b0, 3'd0, 1, 2, 0};
        tbl[15] = '{0, 1, 3'd4, 1, 3, 8'b001, 1'b0, 3'd0, 11, 0, 0};

        do_reset();
        chk("rst_ready", chg_ready, 1);
        chk("rst_eject", eject, 0);
        chk("rst_done", done, 0);
        chk("rst_short", short, 0);
        chk("rst_fault", fault, 0);
        chk("rst_owed", owed, 0);
        chk("rst_cnt1", cnt1, 8);
        chk("rst_cnt2", cnt2, 8);

        for (int i = 0; i < NV; i++) begin
            repeat (tbl[i].ref1) refill_pulse(1'b0);
            repeat (tbl[i].ref2) refill_pulse(1'b1);
            run_req(tbl[i].amt, tbl[i].wt, n, sels, sh, ow, lat, fe);
            chk($sformatf("v%0d_lat", i), lat, tbl[i].lat);
            chk($sformatf("v%0d_coins", i), n, tbl[i].n);
            chk($sformatf("v%0d_sels", i), sels, tbl[i].sels);
            chk($sformatf("v%0d_short", i), sh, tbl[i].sh);
            chk($sformatf("v%0d_owed", i), ow, tbl[i].ow);
            chk($sformatf("v%0d_cnt1", i), cnt1, tbl[i].c1);
            chk($sformatf("v%0d_cnt2", i), cnt2, tbl[i].c2);
            if (tbl[i].n > 0)
                chk($sformatf("v%0d_first_eject", i), fe, 2);
            @(negedge clk);
            chk($sformatf("v%0d_ready_back", i), chg_ready, 1);
            chk($sformatf("v%0d_done_pulse", i), done, 0);
        end

        // Stray ack while idle, then refill colliding with an ejection.
        do_reset();
        @(negedge clk);
        eject_done = 1'b1;
        @(negedge clk);
        eject_done = 1'b0;
        chk("idle_ack_cnt1", cnt1, 8);
        chk("idle_ack_cnt2", cnt2, 8);
        chk("idle_ack_ready", chg_ready, 1);
        chg_valid = 1'b1;
        chg_amt   = 3'd2;
        @(negedge clk);
        chg_valid = 1'b0;
        k = 0;
        while (!eject && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("coll_eject_seen", eject, 1);
        chk("coll_eject_sel", eject_sel, 1);
        eject_done = 1'b1;
        refill     = 1'b1;
        refill_sel = 1'b1;
        @(negedge clk);
        eject_done = 1'b0;
        refill     = 1'b0;
        chk("coll_cnt2", cnt2, 8);
        chk("coll_cnt1", cnt1, 8);
        k = 0;
        while (!done && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("coll_done", done, 1);
        chk("coll_short", short, 0);
        repeat (8) refill_pulse(1'b0);
        chk("sat_cnt1", cnt1, 15);

        // Ejector never acknowledges.
        do_reset();
        @(negedge clk);
        chg_valid = 1'b1;
        chg_amt   = 3'd1;
        @(negedge clk);
        chg_valid = 1'b0;
        k = 0;
        while (!eject && k < 50) begin
            @(negedge clk);
            k++;
        end
        ehigh = 0;
        while (eject && ehigh < 100) begin
            ehigh++;
            @(negedge clk);
        end
        chk("to_eject_cycles", ehigh, 16);
        chk("to_fault", fault, 1);
        chk("to_ready", chg_ready, 0);
        chg_valid = 1'b1;
        chg_amt   = 3'd3;
        @(negedge clk);
        chg_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("to_ignored_eject", eject, 0);
        chk("to_ignored_ready", chg_ready, 0);
        chk("to_owed_frozen", owed, 1);
        chk("to_fault_sticky", fault, 1);
        refill_pulse(1'b0);
        chk("to_refill_cnt1", cnt1, 9);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("to_rst_fault", fault, 0);
        chk("to_rst_ready", chg_ready, 1);
        chk("to_rst_cnt1", cnt1, 8);
        chk("to_rst_cnt2", cnt2, 8);
        chk("to_rst_owed", owed, 0);

        // Reset while a coin is in flight.
        @(negedge clk);
        chg_valid = 1'b1;
        chg_amt   = 3'd3;
        @(negedge clk);
        chg_valid = 1'b0;
        k = 0;
        while (!eject && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("mid_eject_seen", eject, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_eject", eject, 0);
        chk("mid_ready", chg_ready, 1);
        chk("mid_cnt1", cnt1, 8);
        chk("mid_cnt2", cnt2, 8);
        chk("mid_owed", owed, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vending_change_dispenser.md
# vending_change_dispenser

- Sits downstream of the vending machine and consumes its 3-bit `change` result.
- Each accepted request pays out the owed amount as physical coins from two tubes, one coin per ejector handshake.
  - 2-unit coins are paid first (greedy), then 1-unit coins.
  - The block never overpays.
- Tracks tube inventory, supports refill, reports shortfall, and latches a fault if the ejector stops acknowledging.

## Interface
Parameters:
- `TUBE_W`, 4: width of each tube counter.
- `TUBE_DEPTH`, 15: tube capacity; counts saturate here. Must be ≤ 2^TUBE_W−1.
- `INIT_CNT`, 8: count loaded into both tubes on reset.
- `TIMEOUT`, 16: maximum number of cycles `eject` stays high awaiting `eject_done`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `chg_valid` in 1: change request strobe; sampled only when `chg_ready` is high.
- `chg_amt` in 3: amount owed, in units (0..7).
- `chg_ready` out 1: block is idle and can accept a request.
- `eject` out 1: coin-eject request, held high until acknowledged or timed out.
- `eject_sel` out 1: 0 = 1-unit tube, 1 = 2-unit tube; stable while `eject` is high.
- `eject_done` in 1: one-cycle acknowledge from the mechanism.
- `refill` in 1, `refill_sel` in 1: add one coin to the selected tube (same encoding as `eject_sel`).
- `cnt1`, `cnt2` out TUBE_W: current tube counts.
- `owed` out 3: remaining amount for the current request.
- `done` out 1: one-cycle pulse when a request completes.
- `short` out 1: valid only with `done`; 1 = full amount not paid.
- `fault` out 1: sticky ejector-timeout flag.

## Operation
- **Reset values:**
  - State = IDLE; `chg_ready`=1.
  - `eject`, `eject_sel`, `done`, `short`, `fault`, `owed` = 0.
  - `cnt1` = `cnt2` = INIT_CNT; internal timer = 0.
- **IDLE:**
  - `chg_valid` with `chg_amt`≠0: latch `owed`=`chg_amt`, go to SELECT.
  - `chg_valid` with `chg_amt`=0: go directly to FINISH with `short`=0.
- **SELECT** (one cycle; first matching rule applies):
  - `owed`=0 → FINISH, `short`=0.
  - `owed`≥2 and `cnt2`>0 → `eject_sel`=1, go to EJECT.
  - `cnt1`>0 → `eject_sel`=0, go to EJECT.
  - Otherwise → FINISH, `short`=1. This includes the case `owed`=1, `cnt1`=0, `cnt2`>0: no overpay.
- **EJECT:**
  - `eject`=1; timer increments each cycle.
  - `eject_done` is honored in any EJECT cycle, including the first. On it:
    - decrement the selected tube;
    - `owed` −= coin value (1 or 2);
    - clear the timer; go to SELECT.
  - If timer reaches TIMEOUT−1 without `eject_done` → FAULT.
- **FINISH:** `done`=1 for one cycle, `short` as decided, then IDLE.
- **FAULT:**
  - `fault`=1; `eject`=0; `chg_ready`=0.
  - `owed` frozen. Exit only by `rst`.
- **Arithmetic rules:**
  - Refill saturates at TUBE_DEPTH.
  - Decrement is guarded by the SELECT checks and never underflows.
  - Refill and eject-decrement on the same tube in the same cycle: both apply (net unchanged).
  - Refill is accepted in every state, including FAULT.
- `eject_done` outside EJECT is ignored.
- `chg_valid` while `chg_ready`=0 is ignored (not queued).

## Timing
- Request accepted at edge N (IDLE); SELECT occupies cycle N+1; `eject` first high in cycle N+2.
- Each coin costs 1 SELECT cycle plus the EJECT cycles up to and including the `eject_done` cycle.
- Example: `chg_amt`=3 with `eject_done` in the first EJECT cycle each time.
  - `eject` is high in cycles N+2 (sel=1) and N+4 (sel=0).
  - `done` is high in cycle N+6.
  - `chg_ready` returns in cycle N+7.
- Maximum `eject` high time is TIMEOUT cycles; `fault` rises the following cycle.
- `rst` mid-request:
  - all outputs take reset values on the next edge;
  - tubes reload INIT_CNT;
  - the in-flight coin is forgotten.

## Structure
- Shared package `vending_pkg` holds:
  - state enum (IDLE, SELECT, EJECT, FINISH, FAULT);
  - coin-select constants COIN1=1'b0, COIN2=1'b1;
  - coin values 1 and 2;
  - the width of the `chg_amt`/`owed` field (3).
- One sub-module, `coin_tube`, instantiated twice:
  - a saturating up/down counter with `inc`, `dec`, and reset-load to INIT_CNT;
  - exposes `count` and `empty`.

## Test plan
- Reset, then `chg_amt`=3 with immediate `eject_done`:
  - ejections sel=1 then sel=0;
  - `cnt2`=7, `cnt1`=7;
  - `done`=1, `short`=0 six cycles after acceptance.
- Set `cnt2`=0 (drain via 8 requests of 2, ack each), then `chg_amt`=2:
  - two sel=0 ejections; `cnt1` decreases by 2; `short`=0.
- Drain `cnt1` to 0 with `cnt2`>0, then `chg_amt`=5:
  - two sel=1 ejections; then `done` with `short`=1 and `owed`=1.
- Withhold `eject_done`:
  - `eject` high exactly 16 cycles, then `fault`=1 and `chg_ready`=0;
  - later `chg_valid` ignored; `rst` clears everything and restores counts to 8.
- Refill sel=0 eight times from 8:
  - `cnt1` saturates at 15.
  - Refill sel=1 in the same cycle as a sel=1 `eject_done`: `cnt2` unchanged.
- `chg_amt`=0 request: `done`=1, `short`=0 in cycle N+1; no `eject`.
- `rst` during EJECT: next cycle `eject`=0, `chg_ready`=1, counts=8.
